// File: rtl/intrapred_pkg.sv
// Shared types for the intra-prediction frame sequencer.
// Provides the FSM state enum, stage-enable codes and blocks per MB.
package intrapred_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NP,
    PRED,
    RES,
    SAD,
    OUT
  } seq_state_t;

  localparam logic [3:0] EN_NP   = 4'b0001;
  localparam logic [3:0] EN_PRED = 4'b0010;
  localparam logic [3:0] EN_RES  = 4'b0100;
  localparam logic [3:0] EN_SAD  = 4'b1000;

  localparam int LUMA_PER_MB = 16;

endpackage

// File: rtl/intrapred_stage_timer.sv
// Stage dwell timer: load starts a STAGE_CYCLES-long window.
// Ports: clk, clear (sync), load; expire is high in the window's last cycle.
module intrapred_stage_timer #(
  parameter int STAGE_CYCLES = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  output logic expire
);

  localparam int W = $clog2(STAGE_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(STAGE_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/intrapred_sequencer.sv
// Frame controller walking luma 4x4 / chroma 8x8 blocks through the datapath.
// Ports: start/abort control, one-hot enabler, block numbers, valid/ready out.
module intrapred_sequencer
  import intrapred_pkg::*;
#(
  parameter int NUM_MB       = 99,
  parameter int STAGE_CYCLES = 2,
  parameter int NUM_BITS     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [3:0]          enabler,
  output logic [NUM_BITS-1:0] mbnumber_luma4x4,
  output logic [NUM_BITS-1:0] mbnumber_chromab8x8,
  output logic [NUM_BITS-1:0] mbnumber_chromar8x8,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_chroma_valid,
  output logic                out_last
);

  localparam logic [NUM_BITS-1:0] LAST_LUMA =
    NUM_BITS'(NUM_MB * LUMA_PER_MB - 1);

  seq_state_t          r_state;
  logic [3:0]          r_en;
  logic [NUM_BITS-1:0] r_luma;
  logic [NUM_BITS-1:0] r_chroma;
  logic                r_busy;
  logic                r_done;
  logic                r_valid;
  logic                r_cv;
  logic                r_last;

  logic w_expire;
  logic w_stage;
  logic w_load;
  logic w_mb_end;
  logic w_is_last;

  assign w_stage = (r_state == NP) || (r_state == PRED) ||
                   (r_state == RES) || (r_state == SAD);

  // Reload on every stage entry: from IDLE, stage-to-stage, OUT->NP.
  assign w_load = ((r_state == IDLE) && start) ||
                  (w_stage && w_expire) ||
                  ((r_state == OUT) && out_ready);

  assign w_mb_end  = (r_luma[3:0] == 4'hF);
  assign w_is_last = (r_luma == LAST_LUMA);

  intrapred_stage_timer #(
    .STAGE_CYCLES(STAGE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .clear (reset || abort),
    .load  (w_load),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (reset || abort) begin
      r_state  <= IDLE;
      r_en     <= '0;
      r_luma   <= '0;
      r_chroma <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_cv     <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= NP;
            r_en    <= EN_NP;
            r_busy  <= 1'b1;
          end
        end
        NP: begin
          if (w_expire) begin
            r_state <= PRED;
            r_en    <= EN_PRED;
          end
        end
        PRED: begin
          if (w_expire) begin
            r_state <= RES;
            r_en    <= EN_RES;
          end
        end
        RES: begin
          if (w_expire) begin
            r_state <= SAD;
            r_en    <= EN_SAD;
          end
        end
        SAD: begin
          if (w_expire) begin
            r_state <= OUT;
            r_en    <= '0;
            r_valid <= 1'b1;
            r_cv    <= w_mb_end;
            r_last  <= w_is_last;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_cv    <= 1'b0;
            r_last  <= 1'b0;
            if (w_is_last) begin
              r_state  <= IDLE;
              r_luma   <= '0;
              r_chroma <= '0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= NP;
              r_en    <= EN_NP;
              r_luma  <= r_luma + 1'b1;
              if (w_mb_end) begin
                r_chroma <= r_chroma + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= '0;
        end
      endcase
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign enabler             = r_en;
  assign mbnumber_luma4x4    = r_luma;
  assign mbnumber_chromab8x8 = r_chroma;
  assign mbnumber_chromar8x8 = r_chroma;
  assign out_valid           = r_valid;
  assign out_chroma_valid    = r_cv;
  assign out_last            = r_last;

endmodule

// File: tb/tb_intrapred_sequencer.sv
// Bench for intrapred_sequencer: timing table, block scoreboard, corners.
// Second instance runs NUM_MB=1, STAGE_CYCLES=1.
module tb_intrapred_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic        busy, done, out_valid, out_cv, out_last;
  logic [3:0]  enabler;
  logic [31:0] luma, cb, cr;

  logic        s_start, s_busy, s_done, s_valid, s_cv, s_last;
  logic [3:0]  s_en;
  logic [31:0] s_luma, s_cb, s_cr;

  always #5 clk = ~clk;

  intrapred_sequencer #(
    .NUM_MB(2), .STAGE_CYCLES(2), .NUM_BITS(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .enabler(enabler),
    .mbnumber_luma4x4(luma),
    .mbnumber_chromab8x8(cb),
    .mbnumber_chromar8x8(cr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_chroma_valid(out_cv), .out_last(out_last)
  );

  intrapred_sequencer #(
    .NUM_MB(1), .STAGE_CYCLES(1), .NUM_BITS(32)
  ) dut1 (
    .clk(clk), .reset(reset), .start(s_start), .abort(1'b0),
    .busy(s_busy), .done(s_done), .enabler(s_en),
    .mbnumber_luma4x4(s_luma),
    .mbnumber_chromab8x8(s_cb),
    .mbnumber_chromar8x8(s_cr),
    .out_valid(s_valid), .out_ready(1'b1),
    .out_chroma_valid(s_cv), .out_last(s_last)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  en;
    logic        valid;
    logic        busy;
    logic [31:0] luma;
    logic        done;
  } vec_t;

  typedef struct {
    logic [31:0] luma;
    logic [31:0] chroma;
    logic        cv;
    logic        last;
    int          cyc;
  } exp_t;

  vec_t tbl [14];
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_en"}, 32'(enabler), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_luma"}, luma, 0);
    chk({nm, "_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    tbl[0]  = '{0,   4'b0000, 0, 0, 0,  0};
    tbl[1]  = '{1,   4'b0001, 0, 1, 0,  0};
    tbl[2]  = '{2,   4'b0001, 0, 1, 0,  0};
    tbl[3]  = '{3,   4'b0010, 0, 1, 0,  0};
    tbl[4]  = '{4,   4'b0010, 0, 1, 0,  0};
    tbl[5]  = '{5,   4'b0100, 0, 1, 0,  0};
    tbl[6]  = '{6,   4'b0100, 0, 1, 0,  0};
    tbl[7]  = '{7,   4'b1000, 0, 1, 0,  0};
    tbl[8]  = '{8,   4'b1000, 0, 1, 0,  0};
    tbl[9]  = '{9,   4'b0000, 1, 1, 0,  0};
    tbl[10] = '{10,  4'b0001, 0, 1, 1,  0};
    tbl[11] = '{288, 4'b0000, 1, 1, 31, 0};
    tbl[12] = '{289, 4'b0000, 0, 0, 0,  1};
    tbl[13] = '{290, 4'b0000, 0, 0, 0,  0};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    out_ready = 1'b1; s_start = 1'b0;
    tick(); tick();
    idle_chk("rst");
    chk("rst_cb", cb, 0);
    chk("rst_cv", 32'(out_cv), 0);
    chk("rst_last", 32'(out_last), 0);
    reset = 1'b0;
    tick();

    // Full frame with ready high; scoreboard loaded at start.
    for (int k = 0; k < 32; k++)
      sb.push_back('{32'(k), 32'(k / 16), (k % 16) == 15,
                     k == 31, 9 * k + 9});
    begin
      int ti = 0;
      cyc = 0;
      start = 1'b1;
      for (int n = 0; n < 296; n++) begin
        if (ti < 14 && tbl[ti].cyc == cyc) begin
          chk("t_en", 32'(enabler), 32'(tbl[ti].en));
          chk("t_valid", 32'(out_valid), 32'(tbl[ti].valid));
          chk("t_busy", 32'(busy), 32'(tbl[ti].busy));
          chk("t_luma", luma, tbl[ti].luma);
          chk("t_done", 32'(done), 32'(tbl[ti].done));
          ti++;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("sb_extra", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_cyc", 32'(cyc), 32'(e.cyc));
            chk("sb_luma", luma, e.luma);
            chk("sb_cb", cb, e.chroma);
            chk("sb_cr", cr, e.chroma);
            chk("sb_cv", 32'(out_cv), 32'(e.cv));
            chk("sb_last", 32'(out_last), 32'(e.last));
          end
        end else begin
          chk("cv_idle", 32'(out_cv), 0);
          chk("last_idle", 32'(out_last), 0);
        end
        tick();
        start = 1'b0;
      end
      chk("sb_left", 32'(sb.size()), 0);
      chk("tbl_seen", 32'(ti), 14);
    end

    // Backpressure in first OUT for 5 cycles.
    cyc = 0; start = 1'b1; out_ready = 1'b0;
    tick(); start = 1'b0;
    while (cyc < 9) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_en", 32'(enabler), 0);
      chk("bp_luma", luma, 0);
      chk("bp_cb", cb, 0);
      chk("bp_busy", 32'(busy), 1);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_hold", 32'(out_valid), 1);
    tick();
    chk("bp_adv_en", 32'(enabler), 4'b0001);
    chk("bp_adv_luma", luma, 1);
    chk("bp_adv_valid", 32'(out_valid), 0);

    // Abort during RES of block 1, then verify a clean restart.
    while (cyc < 19) tick();
    chk("ab_res", 32'(enabler), 4'b0100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_chk("ab");
    tick(); tick();
    idle_chk("ab_hold");

    cyc = 0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick(); start = 1'b0;
    chk("sb_busy_en4", 32'(enabler), 4'b0010);
    tick();
    chk("sb_busy_en5", 32'(enabler), 4'b0100);
    while (cyc < 9) tick();
    chk("rs_valid", 32'(out_valid), 1);
    chk("rs_luma", luma, 0);

    // Abort beats a handshake in the same cycle.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_chk("abhs");

    // start with abort in IDLE: no transition.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    idle_chk("sa");
    tick();
    idle_chk("sa2");

    // Reset mid-frame.
    start = 1'b1;
    tick(); start = 1'b0;
    chk("mr_np", 32'(enabler), 4'b0001);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_chk("mr");

    // STAGE_CYCLES=1, one MB: 5-cycle blocks.
    begin
      int hs = 0;
      cyc = 0;
      s_start = 1'b1;
      for (int n = 0; n < 90; n++) begin
        if (s_valid) begin
          hs++;
          chk("p1_cyc", 32'(cyc), 32'(5 * hs));
          chk("p1_luma", s_luma, 32'(hs - 1));
          chk("p1_last", 32'(s_last), 32'(hs == 16));
          chk("p1_cv", 32'(s_cv), 32'(hs == 16));
        end
        chk("p1_done", 32'(s_done), 32'(cyc == 81));
        tick();
        s_start = 1'b0;
      end
      chk("p1_count", 32'(hs), 16);
      chk("p1_busy", 32'(s_busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
